// File: rtl/forward_pkg.sv
// Shared encodings for the ID-stage forwarding and hazard unit: write-back
// source codes, forwarding select codes, hazard causes and multi-cycle-op FSM states.
package forward_pkg;

    localparam logic [1:0] WRREG_ALURESULT = 2'd0;
    localparam logic [1:0] WRREG_MEMDATA   = 2'd1;
    localparam logic [1:0] WRREG_IMMDATA   = 2'd2;
    localparam logic [1:0] WRREG_PCLINK    = 2'd3;

    typedef enum logic [2:0] {
        FOR_RG_ORI    = 3'd0,
        FOR_RG_WB     = 3'd1,
        FOR_RG_MEM    = 3'd2,
        FOR_RG_EX_IMM = 3'd3,
        FOR_RG_EX_ALU = 3'd4
    } for_rg_e;

    typedef enum logic [1:0] {
        HZ_NONE       = 2'd0,
        HZ_LOAD_USE   = 2'd1,
        HZ_LOP_RAW    = 2'd2,
        HZ_LOP_STRUCT = 2'd3
    } hz_cause_e;

    typedef enum logic {
        LOP_IDLE = 1'b0,
        LOP_BUSY = 1'b1
    } lop_state_e;

endpackage

// File: rtl/forward_ctrl_fwd_mux.sv
// One read port's forwarding path: picks the youngest in-flight producer of
// the port's register (EX > MEM > WB) and falls back to the register file.
module fwd_mux
    import forward_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              ex_reg_write,
    input  logic              ex_dm_read,
    input  logic [1:0]        ex_sel,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_imm,
    input  logic [DATA_W-1:0] ex_alu,
    input  logic              mem_reg_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] f_data
);

    for_rg_e sel;
    logic    ex_hit;

    // A load in EX has no value yet, and other EX sources fall through to MEM.
    assign ex_hit = ex_reg_write && !ex_dm_read && (ex_addr == rd_addr);

    always_comb begin
        sel = FOR_RG_ORI;
        if (ex_hit && ex_sel == WRREG_IMMDATA)
            sel = FOR_RG_EX_IMM;
        else if (ex_hit && ex_sel == WRREG_ALURESULT)
            sel = FOR_RG_EX_ALU;
        else if (mem_reg_write && mem_addr == rd_addr)
            sel = FOR_RG_MEM;
        else if (wb_reg_write && wb_addr == rd_addr)
            sel = FOR_RG_WB;
    end

    always_comb begin
        f_data = rd_data;
        case (sel)
            FOR_RG_EX_IMM: f_data = ex_imm;
            FOR_RG_EX_ALU: f_data = ex_alu;
            FOR_RG_MEM:    f_data = mem_data;
            FOR_RG_WB:     f_data = wb_data;
            default:       f_data = rd_data;
        endcase
    end

endmodule

// File: rtl/forward_ctrl.sv
// ID-stage forwarding and hazard unit: per-port operand forwarding, load-use
// tracking, a single multi-cycle-op countdown scoreboard and a stall counter.
module forward_ctrl
    import forward_pkg::*;
#(
    parameter int NUM_RD   = 3,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int LOAD_LAT = 1,
    parameter int LOP_CW   = 4,
    parameter int SCNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_valid,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     adv,
    input  logic                     ex_reg_write,
    input  logic                     ex_dm_read,
    input  logic [1:0]               ex_sel,
    input  logic [ADDR_W-1:0]        ex_addr,
    input  logic [DATA_W-1:0]        ex_imm,
    input  logic [DATA_W-1:0]        ex_alu,
    input  logic                     mem_reg_write,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     wb_reg_write,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     lop_issue,
    input  logic [ADDR_W-1:0]        lop_addr,
    input  logic [LOP_CW-1:0]        lop_cycles,
    output logic [NUM_RD*DATA_W-1:0] f_rd_data,
    output logic                     do_hazard,
    output logic [1:0]               hazard_cause,
    output logic                     lop_busy,
    output logic                     lop_done,
    output logic [SCNT_W-1:0]        stall_cnt
);

    localparam int LDC_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    logic              ld_pend;
    logic [LDC_W-1:0]  ld_cnt;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_start;

    lop_state_e        lop_state, lop_state_nx;
    logic [LOP_CW-1:0] lop_cnt, lop_cnt_nx, issue_cycles;
    logic [ADDR_W-1:0] lop_dest, lop_dest_nx;
    logic              lop_done_nx;

    logic [NUM_RD-1:0] ld_hit, raw_hit;
    hz_cause_e         cause;

    genvar i;
    generate
        for (i = 0; i < NUM_RD; i++) begin : g_port
            logic [ADDR_W-1:0] a;
            assign a = rd_addr[i*ADDR_W +: ADDR_W];

            fwd_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
                .rd_addr      (a),
                .rd_data      (rd_data[i*DATA_W +: DATA_W]),
                .ex_reg_write (ex_reg_write),
                .ex_dm_read   (ex_dm_read),
                .ex_sel       (ex_sel),
                .ex_addr      (ex_addr),
                .ex_imm       (ex_imm),
                .ex_alu       (ex_alu),
                .mem_reg_write(mem_reg_write),
                .mem_addr     (mem_addr),
                .mem_data     (mem_data),
                .wb_reg_write (wb_reg_write),
                .wb_addr      (wb_addr),
                .wb_data      (wb_data),
                .f_data       (f_rd_data[i*DATA_W +: DATA_W])
            );

            assign ld_hit[i]  = rd_valid[i] &&
                                ((ex_dm_read && ex_reg_write && ex_addr == a) ||
                                 (ld_pend && ld_addr == a));
            assign raw_hit[i] = rd_valid[i] && (lop_state == LOP_BUSY) && (lop_dest == a);
        end
    endgenerate

    // An issue landing on the final countdown cycle is accepted, so it is not a conflict.
    always_comb begin
        cause = HZ_NONE;
        if (|ld_hit)
            cause = HZ_LOAD_USE;
        else if (|raw_hit)
            cause = HZ_LOP_RAW;
        else if (lop_state == LOP_BUSY && lop_issue && lop_cnt != LOP_CW'(1))
            cause = HZ_LOP_STRUCT;
    end

    assign hazard_cause = cause;
    assign do_hazard    = (cause != HZ_NONE);
    assign lop_busy     = (lop_state == LOP_BUSY);

    assign ld_start = adv && !do_hazard && ex_dm_read && ex_reg_write && (LOAD_LAT > 1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_pend <= 1'b0;
            ld_cnt  <= '0;
        end else if (ld_start) begin
            ld_pend <= 1'b1;
            ld_cnt  <= LDC_W'(LOAD_LAT - 1);
        end else if (ld_pend) begin
            ld_cnt <= ld_cnt - LDC_W'(1);
            if (ld_cnt == LDC_W'(1))
                ld_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_start)
            ld_addr <= ex_addr;
    end

    assign issue_cycles = (lop_cycles == '0) ? LOP_CW'(1) : lop_cycles;

    always_comb begin
        lop_state_nx = lop_state;
        lop_cnt_nx   = lop_cnt;
        lop_dest_nx  = lop_dest;
        lop_done_nx  = 1'b0;
        case (lop_state)
            LOP_IDLE: begin
                if (lop_issue) begin
                    lop_state_nx = LOP_BUSY;
                    lop_cnt_nx   = issue_cycles;
                    lop_dest_nx  = lop_addr;
                end
            end
            LOP_BUSY: begin
                if (lop_cnt == LOP_CW'(1)) begin
                    lop_done_nx = 1'b1;
                    if (lop_issue) begin
                        lop_cnt_nx  = issue_cycles;
                        lop_dest_nx = lop_addr;
                    end else begin
                        lop_state_nx = LOP_IDLE;
                    end
                end else begin
                    lop_cnt_nx = lop_cnt - LOP_CW'(1);
                end
            end
            default: lop_state_nx = LOP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lop_state <= LOP_IDLE;
            lop_cnt   <= '0;
            lop_done  <= 1'b0;
        end else begin
            lop_state <= lop_state_nx;
            lop_cnt   <= lop_cnt_nx;
            lop_done  <= lop_done_nx;
        end
    end

    always_ff @(posedge clk) begin
        lop_dest <= lop_dest_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            stall_cnt <= '0;
        else if (do_hazard && stall_cnt != '1)
            stall_cnt <= stall_cnt + SCNT_W'(1);
    end

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed bench for forward_ctrl with LOAD_LAT=3: forwarding priority,
// load-use tracking, multi-cycle-op scoreboard, stall counter and reset.
module tb_forward_ctrl;

    localparam int NUM_RD = 3;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int LOP_CW = 4;
    localparam int SCNT_W = 16;

    logic                     clk;
    logic                     rst;
    logic [NUM_RD-1:0]        rd_valid;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     adv;
    logic                     ex_reg_write, ex_dm_read;
    logic [1:0]               ex_sel;
    logic [ADDR_W-1:0]        ex_addr;
    logic [DATA_W-1:0]        ex_imm, ex_alu;
    logic                     mem_reg_write;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_data;
    logic                     wb_reg_write;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     lop_issue;
    logic [ADDR_W-1:0]        lop_addr;
    logic [LOP_CW-1:0]        lop_cycles;
    logic [NUM_RD*DATA_W-1:0] f_rd_data;
    logic                     do_hazard;
    logic [1:0]               hazard_cause;
    logic                     lop_busy, lop_done;
    logic [SCNT_W-1:0]        stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    forward_ctrl #(
        .NUM_RD(NUM_RD), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .LOAD_LAT(3), .LOP_CW(LOP_CW), .SCNT_W(SCNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data), .adv(adv),
        .ex_reg_write(ex_reg_write), .ex_dm_read(ex_dm_read), .ex_sel(ex_sel),
        .ex_addr(ex_addr), .ex_imm(ex_imm), .ex_alu(ex_alu),
        .mem_reg_write(mem_reg_write), .mem_addr(mem_addr), .mem_data(mem_data),
        .wb_reg_write(wb_reg_write), .wb_addr(wb_addr), .wb_data(wb_data),
        .lop_issue(lop_issue), .lop_addr(lop_addr), .lop_cycles(lop_cycles),
        .f_rd_data(f_rd_data), .do_hazard(do_hazard), .hazard_cause(hazard_cause),
        .lop_busy(lop_busy), .lop_done(lop_done), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        rd_valid = '0; rd_addr = '0;
        rd_data = {32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0};
        adv = 1'b0;
        ex_reg_write = 1'b0; ex_dm_read = 1'b0; ex_sel = 2'd0; ex_addr = '0;
        ex_imm = '0; ex_alu = '0;
        mem_reg_write = 1'b0; mem_addr = '0; mem_data = '0;
        wb_reg_write = 1'b0; wb_addr = '0; wb_data = '0;
        lop_issue = 1'b0; lop_addr = '0; lop_cycles = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        n_cmp++; if (do_hazard !== 1'b0) begin n_err++; $display("FAIL reset_hazard: got %b want 0", do_hazard); end
        n_cmp++; if (hazard_cause !== 2'd0) begin n_err++; $display("FAIL reset_cause: got %0d want 0", hazard_cause); end
        n_cmp++; if (lop_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", lop_busy); end
        n_cmp++; if (lop_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", lop_done); end
        n_cmp++; if (stall_cnt !== 16'h0) begin n_err++; $display("FAIL reset_stall: got %h want 0", stall_cnt); end
    endtask

    task automatic test_ex_forward;
        idle_inputs();
        ex_reg_write = 1'b1; ex_sel = 2'd0; ex_addr = 5'd5;
        ex_alu = 32'h1234; ex_imm = 32'h5555;
        rd_addr = {5'd0, 5'd6, 5'd5}; rd_valid = 3'b001;
        #1;
        n_cmp++; if (f_rd_data[31:0] !== 32'h1234) begin n_err++; $display("FAIL ex_alu: got %h want 1234", f_rd_data[31:0]); end
        n_cmp++; if (do_hazard !== 1'b0) begin n_err++; $display("FAIL ex_alu_hazard: got %b want 0", do_hazard); end
        n_cmp++; if (f_rd_data[63:32] !== 32'hD1D1_D1D1) begin n_err++; $display("FAIL ex_miss_port1: got %h want d1d1d1d1", f_rd_data[63:32]); end
        ex_sel = 2'd2;
        #1;
        n_cmp++; if (f_rd_data[31:0] !== 32'h5555) begin n_err++; $display("FAIL ex_imm: got %h want 5555", f_rd_data[31:0]); end
        ex_sel = 2'd1; mem_reg_write = 1'b1; mem_addr = 5'd5; mem_data = 32'h77;
        #1;
        n_cmp++; if (f_rd_data[31:0] !== 32'h77) begin n_err++; $display("FAIL ex_fallthrough: got %h want 77", f_rd_data[31:0]); end
    endtask

    task automatic test_priority;
        idle_inputs();
        mem_reg_write = 1'b1; mem_addr = 5'd7; mem_data = 32'hAA;
        wb_reg_write = 1'b1; wb_addr = 5'd7; wb_data = 32'hBB;
        rd_addr = {5'd7, 5'd0, 5'd0};
        #1;
        n_cmp++; if (f_rd_data[95:64] !== 32'hAA) begin n_err++; $display("FAIL prio_mem: got %h want aa", f_rd_data[95:64]); end
        mem_reg_write = 1'b0;
        #1;
        n_cmp++; if (f_rd_data[95:64] !== 32'hBB) begin n_err++; $display("FAIL prio_wb: got %h want bb", f_rd_data[95:64]); end
        wb_reg_write = 1'b0;
        #1;
        n_cmp++; if (f_rd_data[95:64] !== 32'hD2D2_D2D2) begin n_err++; $display("FAIL prio_rf: got %h want d2d2d2d2", f_rd_data[95:64]); end
        ex_reg_write = 1'b1; ex_dm_read = 1'b1; ex_addr = 5'd7; rd_valid = 3'b000;
        #1;
        n_cmp++; if (do_hazard !== 1'b0) begin n_err++; $display("FAIL ld_invalid_port: got %b want 0", do_hazard); end
        rd_valid = 3'b100;
        #1;
        n_cmp++; if (hazard_cause !== 2'd1) begin n_err++; $display("FAIL ld_ex_match: got %0d want 1", hazard_cause); end
        idle_inputs();
        #1;
    endtask

    task automatic test_load_lat;
        idle_inputs();
        ex_reg_write = 1'b1; ex_dm_read = 1'b1; ex_addr = 5'd3; adv = 1'b1;
        tick();
        ex_reg_write = 1'b0; ex_dm_read = 1'b0; ex_addr = 5'd0;
        rd_valid = 3'b001; rd_addr = {5'd0, 5'd0, 5'd3};
        #1;
        n_cmp++; if (hazard_cause !== 2'd1) begin n_err++; $display("FAIL ld_pend_c1: got %0d want 1", hazard_cause); end
        tick();
        n_cmp++; if (hazard_cause !== 2'd1) begin n_err++; $display("FAIL ld_pend_c2: got %0d want 1", hazard_cause); end
        tick();
        n_cmp++; if (hazard_cause !== 2'd0) begin n_err++; $display("FAIL ld_pend_c3: got %0d want 0", hazard_cause); end
        n_cmp++; if (do_hazard !== 1'b0) begin n_err++; $display("FAIL ld_pend_c3_hz: got %b want 0", do_hazard); end
        idle_inputs();
    endtask

    task automatic test_lop;
        idle_inputs();
        lop_issue = 1'b1; lop_cycles = 4'd4; lop_addr = 5'd9;
        tick();
        lop_issue = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            rd_valid = (k == 2) ? 3'b010 : 3'b000;
            rd_addr = {5'd0, 5'd9, 5'd0};
            #1;
            n_cmp++; if (lop_busy !== 1'b1) begin n_err++; $display("FAIL lop_busy_c%0d: got %b want 1", k, lop_busy); end
            n_cmp++; if (lop_done !== 1'b0) begin n_err++; $display("FAIL lop_early_done_c%0d: got %b want 0", k, lop_done); end
            if (k == 2) begin
                n_cmp++; if (hazard_cause !== 2'd2) begin n_err++; $display("FAIL lop_raw: got %0d want 2", hazard_cause); end
            end
            tick();
        end
        rd_valid = 3'b000;
        #1;
        n_cmp++; if (lop_busy !== 1'b0) begin n_err++; $display("FAIL lop_idle_c5: got %b want 0", lop_busy); end
        n_cmp++; if (lop_done !== 1'b1) begin n_err++; $display("FAIL lop_done_c5: got %b want 1", lop_done); end
        tick();
        n_cmp++; if (lop_done !== 1'b0) begin n_err++; $display("FAIL lop_done_c6: got %b want 0", lop_done); end
    endtask

    task automatic test_back_to_back;
        idle_inputs();
        lop_issue = 1'b1; lop_cycles = 4'd3; lop_addr = 5'd10;
        tick();
        lop_cycles = 4'd2; lop_addr = 5'd11;
        #1;
        n_cmp++; if (hazard_cause !== 2'd3) begin n_err++; $display("FAIL lop_struct_c1: got %0d want 3", hazard_cause); end
        n_cmp++; if (do_hazard !== 1'b1) begin n_err++; $display("FAIL lop_struct_hz: got %b want 1", do_hazard); end
        tick();
        n_cmp++; if (hazard_cause !== 2'd3) begin n_err++; $display("FAIL lop_struct_c2: got %0d want 3", hazard_cause); end
        lop_issue = 1'b0;
        tick();
        lop_issue = 1'b1;
        tick();
        lop_issue = 1'b0;
        n_cmp++; if (lop_busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_c4: got %b want 1", lop_busy); end
        n_cmp++; if (lop_done !== 1'b1) begin n_err++; $display("FAIL b2b_done_c4: got %b want 1", lop_done); end
        tick();
        rd_valid = 3'b001; rd_addr = {5'd0, 5'd0, 5'd11};
        #1;
        n_cmp++; if (lop_busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_c5: got %b want 1", lop_busy); end
        n_cmp++; if (lop_done !== 1'b0) begin n_err++; $display("FAIL b2b_done_c5: got %b want 0", lop_done); end
        n_cmp++; if (hazard_cause !== 2'd2) begin n_err++; $display("FAIL b2b_new_dest: got %0d want 2", hazard_cause); end
        rd_valid = 3'b000;
        tick();
        n_cmp++; if (lop_busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_c6: got %b want 0", lop_busy); end
        n_cmp++; if (lop_done !== 1'b1) begin n_err++; $display("FAIL b2b_done_c6: got %b want 1", lop_done); end
        tick();
    endtask

    task automatic test_saturate;
        idle_inputs();
        ex_reg_write = 1'b1; ex_dm_read = 1'b1; ex_addr = 5'd1; adv = 1'b1;
        rd_valid = 3'b001; rd_addr = {5'd0, 5'd0, 5'd1};
        repeat (70000) tick();
        n_cmp++; if (stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL stall_sat: got %h want ffff", stall_cnt); end
        n_cmp++; if (do_hazard !== 1'b1) begin n_err++; $display("FAIL stall_hz: got %b want 1", do_hazard); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_lop;
        int done_seen;
        idle_inputs();
        lop_issue = 1'b1; lop_cycles = 4'd5; lop_addr = 5'd12;
        tick();
        lop_issue = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_cmp++; if (lop_busy !== 1'b0) begin n_err++; $display("FAIL rst_lop_busy: got %b want 0", lop_busy); end
        n_cmp++; if (stall_cnt !== 16'h0) begin n_err++; $display("FAIL rst_stall: got %h want 0", stall_cnt); end
        done_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (lop_done !== 1'b0) done_seen++;
            tick();
        end
        n_cmp++; if (done_seen !== 0) begin n_err++; $display("FAIL rst_no_done: got %0d pulses want 0", done_seen); end
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_priority();
        test_load_lat();
        test_lop();
        test_back_to_back();
        test_saturate();
        test_reset_mid_lop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
